pbit_array_gibbs: RTL and testbench

- Parametrised array of N_PBITS p-bits. Each channel owns a 16-bit LFSR. Each channel applies a selectable gain shift with saturation to its signed input and draws a registered stochastic bit.
- Two update modes: parallel (all channels sample on each enable) and sequential Gibbs (one channel per enable, round-robin), with a sweep-complete strobe.
- Sits between the coupling/weight-sum logic, which supplies the inputs, and the state readout / annealing controller, which consumes out and sweep_done.

---
 rtl/pbit_array_gibbs.sv | 102 ++++++++++
 tb/tb_pbit_array_gibbs.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pbit_array_gibbs.sv
`default_nettype none
// ============================================================================
// Module   : pbit_array_gibbs
// Brief    : Array of LFSR-driven stochastic bits with parallel or
//            round-robin Gibbs update and a sweep-complete strobe.
// Revision : 1.0 - initial release
// ============================================================================
module pbit_array_gibbs #(
    parameter int          N_PBITS = 4,
    parameter int          W       = 8,
    parameter logic [15:0] SEED    = 16'hACE1,
    localparam int         IDX_W   = (N_PBITS > 1) ? $clog2(N_PBITS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 mode,
    input  logic [1:0]           gain,
    input  logic [N_PBITS*W-1:0] in_vals,
    output logic [N_PBITS-1:0]   out,
    output logic [IDX_W-1:0]     upd_idx,
    output logic                 sample_valid,
    output logic                 sweep_done
);

    // Three guard bits hold the <<2 result without wrap before clamping.
    localparam int                    SW       = W + 3;
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(N_PBITS - 1);
    localparam logic signed [SW-1:0]  SAT_MAX  = SW'((1 << (W - 1)) - 1);
    localparam logic signed [SW-1:0]  SAT_MIN  = SW'(-(1 << (W - 1)));

    logic [N_PBITS-1:0] w_sel;
    logic [N_PBITS-1:0] w_hit;

    for (genvar i = 0; i < N_PBITS; i++) begin : g_ch
        localparam logic [15:0] SEED_MIX = SEED ^ 16'(i * 32'h9E37);
        localparam logic [15:0] SEED_I   = (SEED_MIX == 16'd0) ? 16'd1 : SEED_MIX;

        logic [15:0]          r_lfsr;
        logic signed [W-1:0]  w_in;
        logic signed [W-1:0]  w_rng;
        logic signed [W-1:0]  w_scaled;
        logic signed [SW-1:0] w_ext;
        logic signed [SW-1:0] w_shift;

        assign w_sel[i] = en && (!mode || (upd_idx == IDX_W'(i)));
        assign w_in     = in_vals[i*W +: W];
        assign w_ext    = {{3{w_in[W-1]}}, w_in};
        assign w_rng    = r_lfsr[W-1:0];

        always_comb begin
            case (gain)
                2'd0:    w_shift = w_ext;
                2'd1:    w_shift = w_ext >>> 1;
                2'd2:    w_shift = w_ext <<< 1;
                default: w_shift = w_ext <<< 2;
            endcase
        end

        always_comb begin
            if (w_shift > SAT_MAX) begin
                w_scaled = W'(SAT_MAX);
            end else if (w_shift < SAT_MIN) begin
                w_scaled = W'(SAT_MIN);
            end else begin
                w_scaled = W'(w_shift);
            end
        end

        // The sample uses the pre-step LFSR value.
        assign w_hit[i] = (w_scaled > w_rng);

        always_ff @(posedge clk) begin
            if (reset) begin
                r_lfsr <= SEED_I;
            end else if (w_sel[i]) begin
                r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out          <= '0;
            upd_idx      <= '0;
            sample_valid <= 1'b0;
            sweep_done   <= 1'b0;
        end else begin
            out          <= (out & ~w_sel) | (w_hit & w_sel);
            sample_valid <= en;
            sweep_done   <= en && (!mode || (upd_idx == LAST_IDX));
            // Parallel mode pins the pointer, discarding any partial sweep.
            if (!mode) begin
                upd_idx <= '0;
            end else if (en) begin
                upd_idx <= (upd_idx == LAST_IDX) ? '0 : upd_idx + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pbit_array_gibbs.sv
`default_nettype none
// ============================================================================
// Module   : tb_pbit_array_gibbs
// Brief    : Self-checking bench for pbit_array_gibbs against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pbit_array_gibbs;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           en;
    logic           mode;
    logic [1:0]     gain;
    logic [N*W-1:0] in_vals;
    logic [N-1:0]   out;
    logic [IW-1:0]  upd_idx;
    logic           sample_valid;
    logic           sweep_done;

    always #5 clk = ~clk;

    pbit_array_gibbs #(.N_PBITS(N), .W(W), .SEED(16'hACE1)) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .mode         (mode),
        .gain         (gain),
        .in_vals      (in_vals),
        .out          (out),
        .upd_idx      (upd_idx),
        .sample_valid (sample_valid),
        .sweep_done   (sweep_done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0]  m_lfsr [N];
    logic [N-1:0] m_out;
    int           m_idx;
    logic         m_valid;
    logic         m_done;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] seed_of(input int ch);
        logic [15:0] s;
        s = 16'hACE1 ^ 16'(ch * 40503);
        return (s == 16'd0) ? 16'd1 : s;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] r);
        return {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
    endfunction

    function automatic int chan_in(input int ch);
        logic signed [W-1:0] t;
        t = in_vals[ch*W +: W];
        return int'(t);
    endfunction

    function automatic int rng_of(input logic [15:0] r);
        int v;
        v = int'(r) % (1 << W);
        if (v >= (1 << (W - 1))) v = v - (1 << W);
        return v;
    endfunction

    // Floor-halving, doubling, quadrupling, then clamp to the W-bit range.
    function automatic int scale(input int v, input int g);
        int s;
        case (g)
            0:       s = v;
            1:       s = (v - (v & 1)) / 2;
            2:       s = v * 2;
            default: s = v * 4;
        endcase
        if (s > (1 << (W - 1)) - 1) s = (1 << (W - 1)) - 1;
        if (s < -(1 << (W - 1)))    s = -(1 << (W - 1));
        return s;
    endfunction

    task automatic tick(input string tag);
        logic [15:0]  nl [N];
        logic [N-1:0] no;
        int           ni;
        logic         nv;
        logic         nd;
        if (reset) begin
            for (int ch = 0; ch < N; ch++) nl[ch] = seed_of(ch);
            no = '0; ni = 0; nv = 1'b0; nd = 1'b0;
        end else begin
            no = m_out; ni = m_idx; nv = en; nd = 1'b0;
            for (int ch = 0; ch < N; ch++) begin
                nl[ch] = m_lfsr[ch];
                if (en && (!mode || ch == m_idx)) begin
                    no[ch] = (scale(chan_in(ch), int'(gain)) > rng_of(m_lfsr[ch]));
                    nl[ch] = lfsr_next(m_lfsr[ch]);
                end
            end
            if (en) nd = !mode || (m_idx == N - 1);
            if (!mode) ni = 0;
            else if (en) ni = (m_idx + 1) % N;
        end
        @(posedge clk);
        #1;
        m_lfsr = nl; m_out = no; m_idx = ni; m_valid = nv; m_done = nd;
        check_value({tag, ".out"},   32'(out),          32'(m_out));
        check_value({tag, ".idx"},   32'(upd_idx),      32'(m_idx));
        check_value({tag, ".valid"}, 32'(sample_valid), 32'(m_valid));
        check_value({tag, ".sweep"}, 32'(sweep_done),   32'(m_done));
    endtask

    task automatic set_all(input int v);
        for (int ch = 0; ch < N; ch++) in_vals[ch*W +: W] = W'(v);
    endtask

    initial begin
        int           ones [N];
        int           pulses;
        logic [N-1:0] prev_out;
        logic [IW-1:0] prev_idx;

        for (int ch = 0; ch < N; ch++) m_lfsr[ch] = 16'd0;
        m_out = '0; m_idx = 0; m_valid = 1'b0; m_done = 1'b0;
        reset = 1'b1; en = 1'b1; mode = 1'b0; gain = 2'd0; in_vals = '0;
        tick("rst");
        tick("rst");

        reset = 1'b0;
        tick("first");
        check_value("first_out0", 32'(out[0]), 32'd1);

        set_all(-128); gain = 2'd3;
        for (int ch = 0; ch < N; ch++) ones[ch] = 0;
        for (int k = 0; k < 1000; k++) begin
            tick("satneg");
            for (int ch = 0; ch < N; ch++) ones[ch] += int'(out[ch]);
        end
        for (int ch = 0; ch < N; ch++) check_value("sat_neg_ones", 32'(ones[ch]), 32'd0);

        set_all(127); gain = 2'd2;
        for (int ch = 0; ch < N; ch++) ones[ch] = 0;
        for (int k = 0; k < 1000; k++) begin
            tick("satpos");
            for (int ch = 0; ch < N; ch++) ones[ch] += int'(out[ch]);
        end
        for (int ch = 0; ch < N; ch++) check_value("sat_pos_ge990", 32'(ones[ch] >= 990), 32'd1);

        set_all(-1); gain = 2'd1;
        for (int k = 0; k < 256; k++) tick("ashift");

        set_all(0); gain = 2'd0;
        for (int ch = 0; ch < N; ch++) ones[ch] = 0;
        for (int k = 0; k < 4096; k++) begin
            tick("balance");
            for (int ch = 0; ch < N; ch++) ones[ch] += int'(out[ch]);
        end
        for (int ch = 0; ch < N; ch++)
            check_value("balance_45_55",
                        32'((ones[ch] * 100 >= 45 * 4096) && (ones[ch] * 100 <= 55 * 4096)), 32'd1);

        for (int ch = 0; ch < N; ch++) in_vals[ch*W +: W] = W'($urandom);
        mode = 1'b1; pulses = 0;
        for (int k = 0; k < 8; k++) begin
            check_value("seq_idx", 32'(upd_idx), 32'(k % 4));
            prev_out = out;
            tick("seq");
            check_value("seq_only_addr", 32'((prev_out ^ out) & ~(N'(1) << (k % 4))), 32'd0);
            check_value("seq_sweep_pos", 32'(sweep_done), 32'(k % 4 == 3));
            pulses += int'(sweep_done);
        end
        check_value("seq_pulses", 32'(pulses), 32'd2);

        tick("pre_hold");
        prev_out = out; prev_idx = upd_idx; en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick("hold");
            check_value("hold_out", 32'(out), 32'(prev_out));
            check_value("hold_idx", 32'(upd_idx), 32'(prev_idx));
            check_value("hold_valid", 32'(sample_valid), 32'd0);
        end
        en = 1'b1;
        for (int k = 0; k < 3; k++) tick("resume");

        tick("abort");
        tick("abort");
        check_value("abort_at2", 32'(upd_idx), 32'd2);
        reset = 1'b1;
        tick("abort_rst");
        check_value("abort_rst_idx", 32'(upd_idx), 32'd0);
        check_value("abort_rst_out", 32'(out), 32'd0);
        check_value("abort_rst_sweep", 32'(sweep_done), 32'd0);
        reset = 1'b0;

        tick("mchg");
        tick("mchg");
        check_value("mchg_at2", 32'(upd_idx), 32'd2);
        mode = 1'b0; en = 1'b0;
        tick("mchg_sw");
        check_value("mchg_idx", 32'(upd_idx), 32'd0);
        check_value("mchg_sweep", 32'(sweep_done), 32'd0);
        mode = 1'b1; en = 1'b1; pulses = 0;
        for (int k = 0; k < 4; k++) begin
            tick("mchg_restart");
            pulses += int'(sweep_done);
        end
        check_value("mchg_pulses", 32'(pulses), 32'd1);

        for (int k = 0; k < 400; k++) begin
            reset = ($urandom_range(0, 63) == 0);
            en    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            gain  = 2'($urandom_range(0, 3));
            for (int ch = 0; ch < N; ch++) in_vals[ch*W +: W] = W'($urandom);
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
